// File: rtl/mmio_console_pkg.sv
// Shared types and constants for the MMIO console responder.
package mmio_console_pkg;

    localparam logic [15:0] DEF_HEX_ADDR  = 16'h1000;
    localparam logic [15:0] DEF_STR_ADDR  = 16'h1002;
    localparam logic [15:0] DEF_STAT_ADDR = 16'h1004;
    localparam logic [7:0]  ASCII_NL      = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StHex,
        StFetch,
        StWait,
        StEmit,
        StNl,
        StDone
    } state_e;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        // 8'h57 is 'a' - 10
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage

// File: rtl/mmio_console.sv
// MMIO console: prints hex values and RAM strings written by the CPU onto a byte stream.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [15:0] HEX_ADDR  = DEF_HEX_ADDR,
    parameter logic [15:0] STR_ADDR  = DEF_STR_ADDR,
    parameter logic [15:0] STAT_ADDR = DEF_STAT_ADDR,
    parameter int unsigned MAX_CHARS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_mem_wrdata,
    output logic [15:0] o_mem_rddata,
    output logic [15:0] o_dma_addr,
    output logic        o_dma_rd,
    input  logic [15:0] i_dma_rddata,
    output logic [7:0]  o_char,
    output logic        o_char_valid,
    input  logic        i_char_ready,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned CntW = $clog2(MAX_CHARS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_CHARS - 1);

    state_e          state_q, state_d;
    logic [15:0]     value_q, value_d;
    logic [1:0]      nib_q, nib_d;
    logic [15:0]     ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      char_q, char_d;
    logic            overrun_q, overrun_d;
    logic            trunc_q, trunc_d;
    logic [15:0]     rddata_q, rddata_d;

    logic hex_wr, str_wr, stat_rd, handshake, trunc_set, busy;
    logic [3:0] nibble;

    assign hex_wr    = i_mem_wr && (i_mem_addr == HEX_ADDR);
    assign str_wr    = i_mem_wr && (i_mem_addr == STR_ADDR);
    assign stat_rd   = i_mem_rd && (i_mem_addr == STAT_ADDR);
    assign handshake = o_char_valid && i_char_ready;
    assign busy      = (state_q != StIdle);

    always_comb begin
        unique case (nib_q)
            2'd0:    nibble = value_q[15:12];
            2'd1:    nibble = value_q[11:8];
            2'd2:    nibble = value_q[7:4];
            default: nibble = value_q[3:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        nib_d     = nib_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        char_d    = char_q;
        trunc_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (hex_wr) begin
                    value_d = i_mem_wrdata;
                    nib_d   = 2'd0;
                    state_d = StHex;
                end else if (str_wr) begin
                    ptr_d   = {i_mem_wrdata[15:1], 1'b0};
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StHex: begin
                if (handshake) begin
                    nib_d = nib_q + 2'd1;
                    if (nib_q == 2'd3) state_d = StNl;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                // A null word ends the string without emitting anything.
                if (i_dma_rddata == 16'h0000) begin
                    state_d = StNl;
                end else begin
                    char_d  = i_dma_rddata[7:0];
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (handshake) begin
                    ptr_d = ptr_q + 16'd2;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        trunc_set = 1'b1;
                        state_d   = StNl;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StNl:    if (handshake) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A set event in the same cycle as a status read wins over the clear.
    always_comb begin
        overrun_d = overrun_q;
        trunc_d   = trunc_q;
        if (stat_rd) begin
            overrun_d = 1'b0;
            trunc_d   = 1'b0;
        end
        if ((hex_wr || str_wr) && busy) overrun_d = 1'b1;
        if (trunc_set) trunc_d = 1'b1;
        rddata_d = stat_rd ? {13'b0, trunc_q, overrun_q, busy} : 16'h0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            value_q   <= 16'h0000;
            nib_q     <= 2'd0;
            ptr_q     <= 16'h0000;
            cnt_q     <= '0;
            char_q    <= 8'h00;
            overrun_q <= 1'b0;
            trunc_q   <= 1'b0;
            rddata_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            nib_q     <= nib_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            char_q    <= char_d;
            overrun_q <= overrun_d;
            trunc_q   <= trunc_d;
            rddata_q  <= rddata_d;
        end
    end

    always_comb begin
        case (state_q)
            StHex:   o_char = nib2ascii(nibble);
            StEmit:  o_char = char_q;
            StNl:    o_char = ASCII_NL;
            default: o_char = 8'h00;
        endcase
    end

    assign o_char_valid = (state_q == StHex) || (state_q == StEmit) || (state_q == StNl);
    assign o_dma_rd     = (state_q == StFetch);
    assign o_dma_addr   = ptr_q;
    assign o_busy       = busy;
    assign o_done       = (state_q == StDone);
    assign o_mem_rddata = rddata_q;

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: hex print, string print, stalls, truncation, overrun, reset.
module tb_mmio_console;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] i_mem_addr = 16'h0000;
    logic        i_mem_rd = 1'b0;
    logic        i_mem_wr = 1'b0;
    logic [15:0] i_mem_wrdata = 16'h0000;
    logic [15:0] o_mem_rddata;
    logic [15:0] o_dma_addr;
    logic        o_dma_rd;
    logic [15:0] i_dma_rddata = 16'h0000;
    logic [7:0]  o_char;
    logic        o_char_valid;
    logic        i_char_ready = 1'b0;
    logic        o_busy;
    logic        o_done;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [15:0] mem [0:32767];
    logic [7:0]  got [$];
    int unsigned got_cyc [$];
    logic [15:0] dma [$];
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned stall_cnt = 0;
    logic        held_v = 1'b0;
    logic [7:0]  held_c = 8'h00;

    mmio_console dut (
        .clk          (clk),
        .reset        (reset),
        .i_mem_addr   (i_mem_addr),
        .i_mem_rd     (i_mem_rd),
        .i_mem_wr     (i_mem_wr),
        .i_mem_wrdata (i_mem_wrdata),
        .o_mem_rddata (o_mem_rddata),
        .o_dma_addr   (o_dma_addr),
        .o_dma_rd     (o_dma_rd),
        .i_dma_rddata (i_dma_rddata),
        .o_char       (o_char),
        .o_char_valid (o_char_valid),
        .i_char_ready (i_char_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_dma_rd) i_dma_rddata <= mem[o_dma_addr[15:1]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the byte channel and DMA port midway between clock edges.
    always @(negedge clk) begin
        if (o_dma_rd) dma.push_back(o_dma_addr);
        if (o_done) done_cnt++;
        if (o_char_valid) begin
            if (held_v) begin
                stall_cnt++;
                check("char_stable", {24'h0, o_char}, {24'h0, held_c});
            end
            held_v = !i_char_ready;
            held_c = o_char;
            if (i_char_ready) begin
                got.push_back(o_char);
                got_cyc.push_back(cyc);
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(posedge clk);
        #1 i_mem_addr = addr; i_mem_wrdata = data; i_mem_wr = 1'b1;
        @(posedge clk);
        #1 i_mem_wr = 1'b0; i_mem_addr = 16'h0000;
    endtask

    task automatic stat_read(output logic [15:0] v);
        @(posedge clk);
        #1 i_mem_addr = 16'h1004; i_mem_rd = 1'b1;
        @(posedge clk);
        #1 i_mem_rd = 1'b0; i_mem_addr = 16'h0000;
        v = o_mem_rddata;
    endtask

    task automatic wait_done(input string tag, input int unsigned max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < int'(max_cyc); i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    task automatic clear_logs();
        got.delete();
        got_cyc.delete();
        dma.delete();
    endtask

    initial begin
        logic [15:0] st;
        int unsigned d0;

        for (int i = 0; i < 32768; i++) mem[i] = 16'h0041 + 16'(i % 26);

        // Reset held while the bus toggles.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 i_mem_addr = (i % 2 == 0) ? 16'h1000 : 16'h1004;
            i_mem_wr = (i % 2 == 0); i_mem_rd = (i % 2 == 1);
            i_mem_wrdata = 16'h1234; i_char_ready = 1'b1;
        end
        @(negedge clk);
        check("reset_outputs", {o_mem_rddata, o_dma_addr},  32'h0);
        check("reset_ctrl", {27'h0, o_char_valid, o_dma_rd, o_busy, o_done, |o_char}, 32'h0);
        i_mem_wr = 1'b0; i_mem_rd = 1'b0; i_mem_addr = 16'h0000;
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'h0, o_busy}, 32'h0);

        // Hex print at full rate.
        clear_logs();
        d0 = done_cnt;
        i_char_ready = 1'b1;
        bus_write(16'h1000, 16'h0a3f);
        check("hex_busy", {31'h0, o_busy}, 32'h1);
        wait_done("hex_done", 20);
        check("hex_len", got.size(), 5);
        if (got.size() == 5) begin
            check("hex_chars", {got[0], got[1], got[2], got[3]}, 32'h30613366);
            check("hex_nl", {24'h0, got[4]}, 32'h0A);
            check("hex_rate", got_cyc[4] - got_cyc[0], 4);
        end
        @(negedge clk);
        check("hex_done_pulse", done_cnt - d0, 1);
        check("hex_busy_after", {31'h0, o_busy}, 32'h0);

        // String "Hi" from 0x0200; high byte of the first word must be ignored.
        mem[16'h0100] = 16'h5548;
        mem[16'h0101] = 16'h0069;
        mem[16'h0102] = 16'h0000;
        clear_logs();
        bus_write(16'h1002, 16'h0201);
        wait_done("str_done", 40);
        check("str_len", got.size(), 3);
        if (got.size() == 3) check("str_chars", {8'h0, got[0], got[1], got[2]}, 32'h0048690A);
        check("str_dma_len", dma.size(), 3);
        if (dma.size() == 3) begin
            check("str_dma0", {16'h0, dma[0]}, 32'h0200);
            check("str_dma12", {dma[1], dma[2]}, 32'h02020204);
        end

        // Same string with ready toggling every cycle.
        clear_logs();
        stall_cnt = 0;
        bus_write(16'h1002, 16'h0200);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk);
                #1 i_char_ready = ~i_char_ready;
                @(negedge clk);
                if (o_done) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("toggle_done", {31'h0, seen}, 32'h1);
        end
        i_char_ready = 1'b1;
        check("toggle_len", got.size(), 3);
        if (got.size() == 3) check("toggle_chars", {8'h0, got[0], got[1], got[2]}, 32'h0048690A);
        check("toggle_stalled", {31'h0, stall_cnt != 0}, 32'h1);

        // No null from 0xFFFE: wraps and truncates at 512 characters.
        mem[16'h0102] = 16'h0043;
        clear_logs();
        bus_write(16'h1002, 16'hFFFE);
        wait_done("trunc_done", 2000);
        check("trunc_len", got.size(), 513);
        if (got.size() == 513) begin
            check("trunc_first", {16'h0, got[0], got[1]}, 32'h4841);
            check("trunc_nl", {24'h0, got[512]}, 32'h0A);
        end
        check("trunc_dma_len", dma.size(), 512);
        if (dma.size() == 512) begin
            check("trunc_wrap", {dma[0], dma[1]}, 32'hFFFE0000);
            check("trunc_dma_last", {16'h0, dma[511]}, 32'h03FC);
        end
        stat_read(st);
        check("trunc_stat", {16'h0, st}, 32'h4);

        // Hex write during a stalled string print: dropped, overrun set.
        mem[16'h0102] = 16'h0000;
        clear_logs();
        i_char_ready = 1'b0;
        bus_write(16'h1002, 16'h0200);
        bus_write(16'h1000, 16'h1234);
        stat_read(st);
        check("overrun_stat1", {16'h0, st}, 32'h3);
        stat_read(st);
        check("overrun_stat2", {16'h0, st}, 32'h1);
        i_char_ready = 1'b1;
        wait_done("overrun_done", 40);
        check("overrun_len", got.size(), 3);
        if (got.size() == 3) check("overrun_chars", {8'h0, got[0], got[1], got[2]}, 32'h0048690A);
        stat_read(st);
        check("overrun_stat3", {16'h0, st}, 32'h0);

        // Reset mid-EMIT, then a normal hex print.
        clear_logs();
        i_char_ready = 1'b0;
        bus_write(16'h1002, 16'h0200);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (o_char_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("emit_reached", {31'h0, seen}, 32'h1);
        end
        reset = 1'b1;
        #1;
        check("midreset", {29'h0, o_char_valid, o_busy, o_dma_rd}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        i_char_ready = 1'b1;
        bus_write(16'h1000, 16'hbeef);
        wait_done("post_reset_done", 20);
        check("post_reset_len", got.size(), 5);
        if (got.size() == 5) begin
            check("post_reset_chars", {got[0], got[1], got[2], got[3]}, 32'h62656566);
            check("post_reset_nl", {24'h0, got[4]}, 32'h0A);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
